// File: rtl/burst_counter.sv
// Transfer word counter and burst sequencer: requests one burst at a time, counts accepted words,
// flags burst/transfer ends. Define BURST_COUNTER_STATS_EN to add the `nburst` completed-burst counter.
module burst_counter #(
    parameter int SIZEBURST = 8,
    parameter int SIZECOUNT = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SIZECOUNT-1:0] len,
    input  logic [SIZEBURST-1:0] sizeburst,
    output logic                 burst_req,
    input  logic                 burst_gnt,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SIZECOUNT-1:0] count,
    output logic                 endburst,
    output logic                 last,
`ifdef BURST_COUNTER_STATS_EN
    output logic [SIZECOUNT-1:0] nburst,
`endif
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [SIZECOUNT-1:0] len_q, len_d;
    logic [SIZECOUNT-1:0] count_q, count_d;
    logic [SIZEBURST-1:0] sb_q, sb_d;
    logic [SIZECOUNT-1:0] count_inc;
    logic [SIZECOUNT-1:0] burst_mask;
    logic                 sb_whole;
    logic                 accept;
    logic                 boundary;
    logic                 word_last;
    logic                 word_endburst;

    // Bit gi of the mask is set when it lies inside the low sb_q bits of the word index.
    generate
        for (genvar gi = 0; gi < SIZECOUNT; gi++) begin : g_mask
            assign burst_mask[gi] = (32'(sb_q) > 32'(gi));
        end
    endgenerate

    always_comb begin
        sb_whole      = (32'(sb_q) >= 32'(SIZECOUNT));
        count_inc     = count_q + SIZECOUNT'(1);
        accept        = (state_q == ST_XFER) && in_valid;
        word_last     = accept && (count_inc == len_q);
        boundary      = !sb_whole && ((count_inc & burst_mask) == '0);
        word_endburst = accept && (boundary || word_last);
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sb_d    = sb_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = len;
                    sb_d    = sizeburst;
                    count_d = '0;
                    state_d = (len != '0) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (burst_gnt) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (accept) begin
                    count_d = count_inc;
                    if (word_last) begin
                        state_d = ST_DONE;
                    end else if (word_endburst) begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            sb_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sb_q    <= sb_d;
            count_q <= count_d;
        end
    end

`ifdef BURST_COUNTER_STATS_EN
    logic [SIZECOUNT-1:0] nburst_q, nburst_d;

    always_comb begin
        nburst_d = nburst_q;
        if ((state_q == ST_IDLE) && start) begin
            nburst_d = '0;
        end else if (word_endburst) begin
            nburst_d = nburst_q + SIZECOUNT'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            nburst_q <= '0;
        end else begin
            nburst_q <= nburst_d;
        end
    end

    assign nburst = nburst_q;
`endif

    assign burst_req = (state_q == ST_REQ);
    assign in_ready  = (state_q == ST_XFER);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign count     = count_q;
    assign endburst  = word_endburst;
    assign last      = word_last;

endmodule

// File: tb/tb_burst_counter.sv
// Directed bench for burst_counter: per-transfer burst/endburst/last pattern, latencies and reset abort.
// Build with BURST_COUNTER_STATS_EN to also check the nburst counter.
module tb_burst_counter;

    logic        clock;
    logic        reset;
    logic        start;
    logic [11:0] len;
    logic [7:0]  sizeburst;
    logic        burst_req;
    logic        burst_gnt;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] count;
    logic        endburst;
    logic        last;
    logic        busy;
    logic        done;
`ifdef BURST_COUNTER_STATS_EN
    logic [11:0] nburst;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    burst_counter #(
        .SIZEBURST(8),
        .SIZECOUNT(12)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .sizeburst(sizeburst),
        .burst_req(burst_req),
        .burst_gnt(burst_gnt),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .count    (count),
        .endburst (endburst),
        .last     (last),
`ifdef BURST_COUNTER_STATS_EN
        .nburst   (nburst),
`endif
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one transfer; records burst_req phases and which word indices carried endburst/last.
    task automatic run_xfer(input logic [11:0] l, input logic [7:0] s, input int gdly,
                            input bit toggle, input bit noisy,
                            output int reqs, output logic [31:0] eb_mask,
                            output logic [31:0] last_mask, output int done_lat,
                            output logic first_req);
        int req_wait = 0;
        int last_cyc = -1;
        int exp_cnt  = 0;
        bit prev_req = 0;
        bit gnt_prev = 0;
        bit fin      = 0;
        reqs = 0; eb_mask = '0; last_mask = '0; done_lat = -1; first_req = 1'bx;
        @(negedge clock);
        start = 1'b1; len = l; sizeburst = s; burst_gnt = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clock);
            if (noisy) begin
                start = cyc[0]; len = 12'd3; sizeburst = 8'd0;
            end
            in_valid  = toggle ? cyc[0] : 1'b1;
            burst_gnt = burst_req && (req_wait >= gdly);
            #1;
            if (cyc == 0) first_req = burst_req;
            check_eq("count", 32'(count), 32'(exp_cnt));
            if (gnt_prev) check_eq("gnt_to_ready", 32'(in_ready), 32'd1);
            if (burst_req && !prev_req) reqs++;
            if (in_valid && in_ready) begin
                if (endburst) eb_mask[count[4:0]] = 1'b1;
                if (last) begin
                    last_mask[count[4:0]] = 1'b1;
                    last_cyc = cyc;
                end
                exp_cnt++;
            end else begin
                check_eq("last_idle", 32'(last), 32'd0);
            end
            if (done) begin
                done_lat = cyc - last_cyc;
                check_eq("busy_in_done", 32'(busy), 32'd1);
                fin = 1;
            end
            gnt_prev = burst_req && burst_gnt;
            req_wait = burst_req ? req_wait + 1 : 0;
            prev_req = burst_req;
        end
        start = 1'b0; in_valid = 1'b0; burst_gnt = 1'b0;
        if (!fin) check_eq("timeout", 32'd0, 32'd1);
    endtask

    task automatic run_and_check(input string name, input logic [11:0] l, input logic [7:0] s,
                                 input int gdly, input bit toggle, input bit noisy,
                                 input int exp_reqs, input logic [31:0] exp_eb,
                                 input logic [31:0] exp_last, input int exp_nb);
        int          reqs;
        int          lat;
        logic [31:0] ebm;
        logic [31:0] lm;
        logic        freq;
        run_xfer(l, s, gdly, toggle, noisy, reqs, ebm, lm, lat, freq);
        check_eq({name, ".first_req"}, 32'(freq), (l != 0) ? 32'd1 : 32'd0);
        check_eq({name, ".reqs"}, 32'(reqs), 32'(exp_reqs));
        check_eq({name, ".endburst"}, ebm, exp_eb);
        check_eq({name, ".last"}, lm, exp_last);
        check_eq({name, ".done_lat"}, 32'(lat), 32'd1);
        @(negedge clock);
        #1;
        check_eq({name, ".done_pulse"}, 32'(done), 32'd0);
        check_eq({name, ".idle"}, 32'(busy), 32'd0);
        check_eq({name, ".final_count"}, 32'(count), 32'(l));
        $display("[TB] %s len=%0d sb=%0d reqs=%0d eb=0x%0h last=0x%0h", name, l, s, reqs, ebm, lm);
`ifdef BURST_COUNTER_STATS_EN
        check_eq({name, ".nburst"}, 32'(nburst), 32'(exp_nb));
`else
        if (exp_nb < 0) check_eq({name, ".nburst_arg"}, 32'(exp_nb), 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; len = '0; sizeburst = '0;
        burst_gnt = 1'b0; in_valid = 1'b0;
        #3;
        check_eq("rst.count", 32'(count), 32'd0);
        check_eq("rst.req", 32'(burst_req), 32'd0);
        check_eq("rst.ready", 32'(in_ready), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        run_and_check("len16_sb2", 12'd16, 8'd2, 1, 1'b0, 1'b0, 4, 32'h8888, 32'h8000, 4);
        run_and_check("len10_sb3", 12'd10, 8'd3, 1, 1'b0, 1'b0, 2, 32'h0280, 32'h0200, 2);
        run_and_check("len0",      12'd0,  8'd2, 1, 1'b0, 1'b0, 0, 32'h0000, 32'h0000, 0);
        run_and_check("len5_sb0",  12'd5,  8'd0, 3, 1'b1, 1'b0, 5, 32'h001F, 32'h0010, 5);

        // Abort mid-transfer with reset at count 6.
        @(negedge clock);
        start = 1'b1; len = 12'd16; sizeburst = 8'd3;
        @(negedge clock);
        start = 1'b0; in_valid = 1'b1; burst_gnt = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (count == 12'd6 && in_ready) break;
            @(negedge clock);
        end
        check_eq("abort.precount", 32'(count), 32'd6);
        reset = 1'b0;
        #1;
        check_eq("abort.count", 32'(count), 32'd0);
        check_eq("abort.req", 32'(burst_req), 32'd0);
        check_eq("abort.ready", 32'(in_ready), 32'd0);
        check_eq("abort.busy", 32'(busy), 32'd0);
        check_eq("abort.done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b0; burst_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check_eq("abort.no_done", 32'(done | busy), 32'd0);
        end

        run_and_check("len4_sb8",  12'd4,  8'd8, 1, 1'b0, 1'b0, 1, 32'h0008, 32'h0008, 1);
        run_and_check("noisy",     12'd8,  8'd2, 1, 1'b0, 1'b1, 2, 32'h0088, 32'h0080, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
